// File: rtl/apb_timer_mc.sv
// apb_timer_mc: NUM_CH-channel APB timer with per-channel prescaler, reload, wrap flags and irq.
// Define TIMER_CMP_EN to build the TCMP registers, compare logic and TSR[2].
module apb_timer_mc #(
    parameter int CNT_W  = 16,
    parameter int NUM_CH = 4
) (
    input  logic              pclk,
    input  logic              preset_n,
    input  logic              psel,
    input  logic              penable,
    input  logic              pwrite,
    input  logic [7:0]        paddr,
    input  logic [15:0]       pwdata,
    output logic [15:0]       prdata,
    output logic              pready,
    output logic              pslverr,
    output logic [NUM_CH-1:0] irq
);

    localparam logic [8:0]       MAP_END = 9'(NUM_CH * 4);
    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

    logic [CNT_W-1:0]  tdr_q [NUM_CH];
    logic [CNT_W-1:0]  tdr_d [NUM_CH];
    logic [CNT_W-1:0]  cnt_q [NUM_CH];
    logic [CNT_W-1:0]  cnt_d [NUM_CH];
    logic [6:0]        tcr_q [NUM_CH];
    logic [6:0]        tcr_d [NUM_CH];
    logic [7:0]        pre_q [NUM_CH];
    logic [7:0]        pre_d [NUM_CH];
    logic [NUM_CH-1:0] of_q, of_d, uf_q, uf_d, cmpFlag;
`ifdef TIMER_CMP_EN
    logic [CNT_W-1:0]  tcmp_q [NUM_CH];
    logic [CNT_W-1:0]  tcmp_d [NUM_CH];
    logic [NUM_CH-1:0] cmp_q, cmp_d, tcmpWr;
`endif

    logic              access, mapped, wrEn;
    logic [2:0]        chSel;
    logic [1:0]        offs;
    logic [NUM_CH-1:0] tdrWr, tcrWr, tsrWr, doLoad, enRise, tick;
    logic              unusedBits;

    assign access     = psel & penable;
    assign mapped     = {1'b0, paddr} < MAP_END;
    assign wrEn       = access & pwrite & mapped;
    assign chSel      = paddr[4:2];
    assign offs       = paddr[1:0];
    assign pready     = 1'b1;
    assign pslverr    = access & ~mapped;
    assign unusedBits = ^pwdata;

`ifdef TIMER_CMP_EN
    assign cmpFlag = cmp_q;
`else
    assign cmpFlag = '0;
`endif

    // A prescaler left above a freshly shortened period ticks at once instead of wrapping through 255.
    always_comb begin
        for (int n = 0; n < NUM_CH; n++) begin
            tdrWr[n]  = wrEn && (chSel == 3'(n)) && (offs == 2'd0);
            tcrWr[n]  = wrEn && (chSel == 3'(n)) && (offs == 2'd1);
            tsrWr[n]  = wrEn && (chSel == 3'(n)) && (offs == 2'd2);
`ifdef TIMER_CMP_EN
            tcmpWr[n] = wrEn && (chSel == 3'(n)) && (offs == 2'd3);
`endif
            doLoad[n] = wrEn && (chSel == 3'(n)) && (offs == 2'd1) && pwdata[7];
            enRise[n] = wrEn && (chSel == 3'(n)) && (offs == 2'd1) && pwdata[4] && !tcr_q[n][4];
            tick[n]   = tcr_q[n][4] &&
                        ({1'b0, pre_q[n]} >= ((9'd2 << tcr_q[n][2:0]) - 9'd1));
            irq[n]    = tcr_q[n][3] & (of_q[n] | uf_q[n] | cmpFlag[n]);
        end
    end

    // Flag sets are applied after the write-0-to-clear mask so a same-cycle hardware set survives.
    always_comb begin
        of_d = of_q;
        uf_d = uf_q;
`ifdef TIMER_CMP_EN
        cmp_d = cmp_q;
`endif
        for (int n = 0; n < NUM_CH; n++) begin
            tdr_d[n] = tdr_q[n];
            cnt_d[n] = cnt_q[n];
            tcr_d[n] = tcr_q[n];
            pre_d[n] = pre_q[n];
`ifdef TIMER_CMP_EN
            tcmp_d[n] = tcmp_q[n];
            if (tcmpWr[n]) begin
                tcmp_d[n] = pwdata[CNT_W-1:0];
            end
`endif
            if (tdrWr[n]) begin
                tdr_d[n] = pwdata[CNT_W-1:0];
            end
            if (tcrWr[n]) begin
                tcr_d[n] = pwdata[6:0];
            end
            if (tsrWr[n]) begin
                of_d[n] = of_q[n] & pwdata[0];
                uf_d[n] = uf_q[n] & pwdata[1];
`ifdef TIMER_CMP_EN
                cmp_d[n] = cmp_q[n] & pwdata[2];
`endif
            end

            if (doLoad[n] || enRise[n] || tick[n]) begin
                pre_d[n] = '0;
            end else if (tcr_q[n][4]) begin
                pre_d[n] = pre_q[n] + 8'd1;
            end

            if (doLoad[n]) begin
                cnt_d[n] = tdr_q[n];
            end else if (tick[n]) begin
                if (!tcr_q[n][5]) begin
                    if (cnt_q[n] == CNT_MAX) begin
                        cnt_d[n] = tcr_q[n][6] ? tdr_q[n] : '0;
                        of_d[n]  = 1'b1;
                    end else begin
                        cnt_d[n] = cnt_q[n] + 1'b1;
                    end
                end else begin
                    if (cnt_q[n] == '0) begin
                        cnt_d[n] = tcr_q[n][6] ? tdr_q[n] : CNT_MAX;
                        uf_d[n]  = 1'b1;
                    end else begin
                        cnt_d[n] = cnt_q[n] - 1'b1;
                    end
                end
`ifdef TIMER_CMP_EN
                if (cnt_d[n] == tcmp_q[n]) begin
                    cmp_d[n] = 1'b1;
                end
`endif
            end
        end
    end

    always_ff @(posedge pclk) begin
        if (!preset_n) begin
            of_q <= '0;
            uf_q <= '0;
`ifdef TIMER_CMP_EN
            cmp_q <= '0;
`endif
            for (int n = 0; n < NUM_CH; n++) begin
                tdr_q[n] <= '0;
                cnt_q[n] <= '0;
                tcr_q[n] <= '0;
                pre_q[n] <= '0;
`ifdef TIMER_CMP_EN
                tcmp_q[n] <= '0;
`endif
            end
        end else begin
            of_q <= of_d;
            uf_q <= uf_d;
`ifdef TIMER_CMP_EN
            cmp_q <= cmp_d;
`endif
            for (int n = 0; n < NUM_CH; n++) begin
                tdr_q[n] <= tdr_d[n];
                cnt_q[n] <= cnt_d[n];
                tcr_q[n] <= tcr_d[n];
                pre_q[n] <= pre_d[n];
`ifdef TIMER_CMP_EN
                tcmp_q[n] <= tcmp_d[n];
`endif
            end
        end
    end

    always_comb begin
        prdata = '0;
        if (access && !pwrite && mapped) begin
            for (int n = 0; n < NUM_CH; n++) begin
                if (chSel == 3'(n)) begin
                    case (offs)
                        2'd0: prdata = 16'(cnt_q[n]);
                        2'd1: prdata = {9'b0, tcr_q[n]};
                        2'd2: prdata = {13'b0, cmpFlag[n], uf_q[n], of_q[n]};
`ifdef TIMER_CMP_EN
                        2'd3: prdata = 16'(tcmp_q[n]);
`else
                        2'd3: prdata = '0;
`endif
                        default: prdata = '0;
                    endcase
                end
            end
        end
    end

endmodule

// File: tb/tb_apb_timer_mc.sv
// Randomised scoreboard bench for apb_timer_mc: a cycle-level behavioural model predicts every read,
// a negedge monitor pops and compares prdata/pslverr/irq. Honours TIMER_CMP_EN like the design.
module tb_apb_timer_mc;

    localparam int CNT_W  = 16;
    localparam int NUM_CH = 4;
    localparam int MAXV   = (1 << CNT_W) - 1;
`ifdef TIMER_CMP_EN
    localparam bit CMP_EN = 1'b1;
`else
    localparam bit CMP_EN = 1'b0;
`endif

    logic              pclk;
    logic              preset_n;
    logic              psel;
    logic              penable;
    logic              pwrite;
    logic [7:0]        paddr;
    logic [15:0]       pwdata;
    logic [15:0]       prdata;
    logic              pready;
    logic              pslverr;
    logic [NUM_CH-1:0] irq;

    int checks = 0;
    int fails  = 0;

    // Behavioural model state: plain integers per channel.
    int       mTdr   [NUM_CH];
    int       mCnt   [NUM_CH];
    int       mPhase [NUM_CH];
    int       mTcmp  [NUM_CH];
    logic [6:0] mCtrl [NUM_CH];
    bit       mOf    [NUM_CH];
    bit       mUf    [NUM_CH];
    bit       mCmp   [NUM_CH];

    logic [15:0]       expData [$];
    bit                expErr  [$];
    logic [NUM_CH-1:0] expIrq  [$];
    string             expTag  [$];

    apb_timer_mc #(.CNT_W(CNT_W), .NUM_CH(NUM_CH)) dut (
        .pclk    (pclk),
        .preset_n(preset_n),
        .psel    (psel),
        .penable (penable),
        .pwrite  (pwrite),
        .paddr   (paddr),
        .pwdata  (pwdata),
        .prdata  (prdata),
        .pready  (pready),
        .pslverr (pslverr),
        .irq     (irq)
    );

    initial begin
        pclk = 1'b0;
        forever #5 pclk = ~pclk;
    end

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            fails++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic void modelReset();
        for (int n = 0; n < NUM_CH; n++) begin
            mTdr[n] = 0; mCnt[n] = 0; mPhase[n] = 0; mTcmp[n] = 0;
            mCtrl[n] = '0; mOf[n] = 0; mUf[n] = 0; mCmp[n] = 0;
        end
    endfunction

    function automatic logic [15:0] modelRead(input logic [7:0] a);
        int n;
        n = int'(a) / 4;
        if (int'(a) >= NUM_CH * 4) return 16'h0;
        case (int'(a) % 4)
            0:       return 16'(mCnt[n]);
            1:       return {9'b0, mCtrl[n]};
            2:       return {13'b0, mCmp[n] & CMP_EN, mUf[n], mOf[n]};
            default: return CMP_EN ? 16'(mTcmp[n]) : 16'h0;
        endcase
    endfunction

    function automatic logic [NUM_CH-1:0] modelIrq();
        logic [NUM_CH-1:0] r;
        r = '0;
        for (int n = 0; n < NUM_CH; n++)
            r[n] = mCtrl[n][3] && (mOf[n] || mUf[n] || (CMP_EN && mCmp[n]));
        return r;
    endfunction

    // One clock edge of the timer rules: count prescaler phase, step on period end, then apply bus writes.
    function automatic void modelStep();
        bit hit, ticked, sOf, sUf, sCmp;
        int period, off;
        if (!preset_n) begin
            modelReset();
            return;
        end
        off = int'(paddr) % 4;
        for (int n = 0; n < NUM_CH; n++) begin
            hit = psel && penable && pwrite && (int'(paddr) < NUM_CH * 4) && (int'(paddr) / 4 == n);
            ticked = 0; sOf = 0; sUf = 0; sCmp = 0;
            period = 2 << mCtrl[n][2:0];
            if (mCtrl[n][4]) begin
                mPhase[n]++;
                if (mPhase[n] >= period) begin
                    mPhase[n] = 0;
                    ticked = 1;
                end
            end
            if (hit && off == 1 && pwdata[7]) begin
                mCnt[n] = mTdr[n];
                mPhase[n] = 0;
            end else if (ticked) begin
                if (!mCtrl[n][5]) begin
                    if (mCnt[n] == MAXV) begin
                        mCnt[n] = mCtrl[n][6] ? mTdr[n] : 0;
                        sOf = 1;
                    end else mCnt[n] = mCnt[n] + 1;
                end else begin
                    if (mCnt[n] == 0) begin
                        mCnt[n] = mCtrl[n][6] ? mTdr[n] : MAXV;
                        sUf = 1;
                    end else mCnt[n] = mCnt[n] - 1;
                end
                sCmp = CMP_EN && (mCnt[n] == mTcmp[n]);
            end
            if (hit && off == 1) begin
                if (pwdata[4] && !mCtrl[n][4]) mPhase[n] = 0;
                mCtrl[n] = pwdata[6:0];
            end
            if (hit && off == 0) mTdr[n] = int'(pwdata) & MAXV;
            if (hit && off == 2) begin
                mOf[n]  = mOf[n] && pwdata[0];
                mUf[n]  = mUf[n] && pwdata[1];
                mCmp[n] = mCmp[n] && pwdata[2];
            end
            if (hit && off == 3 && CMP_EN) mTcmp[n] = int'(pwdata) & MAXV;
            mOf[n]  = mOf[n] || sOf;
            mUf[n]  = mUf[n] || sUf;
            mCmp[n] = mCmp[n] || sCmp;
        end
    endfunction

    task automatic cycle();
        @(posedge pclk);
        modelStep();
        #1;
    endtask

    task automatic idle(input int n);
        repeat (n) cycle();
    endtask

    task automatic apbWrite(input logic [7:0] a, input logic [15:0] d);
        psel = 1'b1; penable = 1'b0; pwrite = 1'b1; paddr = a; pwdata = d;
        cycle();
        penable = 1'b1;
        cycle();
        psel = 1'b0; penable = 1'b0; pwrite = 1'b0;
    endtask

    task automatic apbRead(input logic [7:0] a, input bit useConst, input logic [15:0] constVal,
                           input string tag);
        psel = 1'b1; penable = 1'b0; pwrite = 1'b0; paddr = a;
        cycle();
        penable = 1'b1;
        expData.push_back(useConst ? constVal : modelRead(a));
        expErr.push_back(int'(a) >= NUM_CH * 4);
        expIrq.push_back(modelIrq());
        expTag.push_back(tag);
        cycle();
        psel = 1'b0; penable = 1'b0;
    endtask

    function automatic logic [15:0] pickVal();
        case ($urandom_range(0, 4))
            0:       return 16'h0;
            1:       return 16'h1;
            2:       return 16'(MAXV - 1);
            3:       return 16'(MAXV);
            default: return 16'($urandom & MAXV);
        endcase
    endfunction

    task automatic applyStimulus();
        int op, ch;
        logic [7:0]  base, ua;
        logic [15:0] d;
        op   = int'($urandom_range(0, 9));
        ch   = int'($urandom_range(0, NUM_CH - 1));
        base = 8'(ch * 4);
        case (op)
            0, 1: begin
                d      = 16'($urandom);
                d[2:0] = 3'($urandom_range(0, 2));
                d[7]   = ($urandom_range(0, 3) == 0);
                apbWrite(base + 8'd1, d);
            end
            2: apbWrite(base, pickVal());
            3: apbWrite(base + 8'd2, 16'($urandom));
            4: apbWrite(base + 8'd3, pickVal());
            5, 6, 7: apbRead(base + 8'($urandom_range(0, 3)), 1'b0, 16'h0, "rand_rd");
            8: begin
                ua = 8'($urandom_range(NUM_CH * 4, 255));
                if ($urandom_range(0, 1) == 1) apbWrite(ua, 16'($urandom));
                else apbRead(ua, 1'b0, 16'h0, "rand_unmapped");
            end
            default: idle(int'($urandom_range(1, 20)));
        endcase
    endtask

    // Monitor: pops one expectation per read access phase, independent of the stimulus thread.
    initial begin
        logic [15:0]       d;
        bit                e;
        logic [NUM_CH-1:0] i;
        string             t;
        forever begin
            @(negedge pclk);
            if (preset_n && psel && !penable)
                checkOutput("prdata_setup_zero", 32'(prdata), 32'h0);
            if (preset_n && psel && penable && pwrite)
                checkOutput("wr_pslverr", 32'(pslverr), 32'(int'(paddr) >= NUM_CH * 4));
            if (preset_n && psel && penable && !pwrite) begin
                if (expData.size() == 0) begin
                    checks++;
                    fails++;
                    $display("[TB] FAIL scoreboard_empty: got read of 0x%0h, expected no read", paddr);
                end else begin
                    d = expData.pop_front();
                    e = expErr.pop_front();
                    i = expIrq.pop_front();
                    t = expTag.pop_front();
                    checkOutput({t, "_data"}, 32'(prdata), 32'(d));
                    checkOutput({t, "_pslverr"}, 32'(pslverr), 32'(e));
                    checkOutput({t, "_irq"}, 32'(irq), 32'(i));
                end
            end
        end
    end

    initial begin
        #5000000;
        $display("[TB] FAIL watchdog: got timeout, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        psel = 1'b0; penable = 1'b0; pwrite = 1'b0; paddr = '0; pwdata = '0;
        preset_n = 1'b0;
        idle(3);
        preset_n = 1'b1;
        idle(1);

        checkOutput("reset_pready", 32'(pready), 32'h1);
        checkOutput("reset_irq", 32'(irq), 32'h0);
        for (int a = 0; a < NUM_CH * 4; a++)
            apbRead(8'(a), 1'b1, 16'h0, $sformatf("reset_rd_%02h", a));

        // Up-count overflow on ch0, prescaler period 2.
        apbWrite(8'h00, 16'hFFF0);
        apbWrite(8'h01, 16'h0090);
        idle(31);
        apbRead(8'h00, 1'b1, 16'h0000, "of_cnt");
        apbRead(8'h02, 1'b1, 16'h0001, "of_tsr");

        // Down-count auto-reload on ch1, prescaler period 16.
        apbWrite(8'h04, 16'h0003);
        apbWrite(8'h05, 16'h00F3);
        idle(47);
        apbRead(8'h04, 1'b1, 16'h0000, "arl_cnt0");
        apbRead(8'h06, 1'b1, 16'h0000, "arl_tsr_pre");
        idle(12);
        apbRead(8'h04, 1'b1, 16'h0003, "arl_reload");
        apbRead(8'h06, 1'b1, 16'h0002, "arl_uf");

        // Write-0-to-clear on ch0 with both wrap flags set.
        apbWrite(8'h00, 16'h0000);
        apbWrite(8'h01, 16'h00B0);
        idle(4);
        apbWrite(8'h01, 16'h0000);
        apbRead(8'h02, 1'b1, 16'h0003, "clr_both");
        apbWrite(8'h02, 16'h0002);
        apbRead(8'h02, 1'b1, 16'h0002, "clr_of");
        apbWrite(8'h02, 16'h0001);
        apbRead(8'h02, 1'b1, 16'h0000, "clr_uf");
        apbWrite(8'h02, 16'h0003);
        apbRead(8'h02, 1'b1, 16'h0000, "clr_noop");

        // Clear write lands on the overflow edge: the set must survive.
        apbWrite(8'h00, 16'hFFFE);
        apbWrite(8'h01, 16'h0090);
        idle(2);
        apbWrite(8'h02, 16'h0000);
        apbWrite(8'h01, 16'h0000);
        apbRead(8'h02, 1'b1, 16'h0001, "set_wins");

`ifdef TIMER_CMP_EN
        apbWrite(8'h0B, 16'h0005);
        apbWrite(8'h08, 16'h0000);
        apbWrite(8'h09, 16'h0098);
        idle(8);
        checkOutput("cmp_irq_before", 32'(irq[2]), 32'h0);
        apbRead(8'h0A, 1'b1, 16'h0004, "cmp_tsr");
        checkOutput("cmp_irq_set", 32'(irq[2]), 32'h1);
        apbWrite(8'h0A, 16'h0000);
        checkOutput("cmp_irq_clear", 32'(irq[2]), 32'h0);
        apbWrite(8'h09, 16'h0000);
`else
        apbWrite(8'h0B, 16'h0005);
        apbRead(8'h0B, 1'b1, 16'h0000, "tcmp_absent");
        apbWrite(8'h08, 16'h0000);
        apbWrite(8'h09, 16'h0098);
        idle(12);
        apbRead(8'h0A, 1'b1, 16'h0000, "tsr_nocmp");
        checkOutput("irq2_nocmp", 32'(irq[2]), 32'h0);
        apbWrite(8'h09, 16'h0000);
`endif

        // Unmapped accesses must not disturb any register.
        apbWrite(8'h10, 16'hFFFF);
        apbRead(8'h10, 1'b1, 16'h0000, "unmapped_rd");
        apbRead(8'h01, 1'b1, 16'h0000, "unmapped_tcr0");
        apbRead(8'h0D, 1'b1, 16'h0000, "unmapped_tcr3");

        for (int k = 0; k < 400; k++) applyStimulus();

        // Reset in the middle of counting.
        for (int c = 0; c < NUM_CH; c++) begin
            apbWrite(8'(c * 4), pickVal());
            apbWrite(8'(c * 4 + 1), 16'h0098);
        end
        idle(7);
        preset_n = 1'b0;
        cycle();
        preset_n = 1'b1;
        checkOutput("rst_irq", 32'(irq), 32'h0);
        for (int c = 0; c < NUM_CH; c++) begin
            apbRead(8'(c * 4), 1'b1, 16'h0000, $sformatf("rst_cnt%0d", c));
            apbRead(8'(c * 4 + 2), 1'b1, 16'h0000, $sformatf("rst_tsr%0d", c));
        end

        idle(2);
        checkOutput("scoreboard_drain", 32'(expData.size()), 32'h0);
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
